// File: rtl/gf2m_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gf2m_pkg
// Purpose  : Shared definitions for the GF(2^m) digit-serial multiplier:
//            default digit width / field degree, controller state encoding
//            and a helper computing the number of multiplier digits.
// Revision : 1.0 - initial release
// ============================================================================
package gf2m_pkg;

  localparam int DIGITAL_DEFAULT    = 16;
  localparam int DATA_WIDTH_DEFAULT = 163;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CAL  = 2'b01,
    DONE = 2'b10
  } state_t;

  // One extra digit so that B always covers all m bits (zero-padded on top).
  function automatic int gf2m_ndig(input int data_width, input int digital);
    return data_width / digital + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf2m_mulx_step.sv
`default_nettype none
// ============================================================================
// Module   : gf2m_mulx_step
// Purpose  : One Horner step in GF(2^m): t_out = (t_in * x mod f) ^ (bit_in ? a : 0)
//            with f(x) = x^m + g(x).  Purely combinational.
// Ports    : t_in   [W-1:0] in  - running value
//            a      [W-1:0] in  - multiplicand
//            g      [W-1:0] in  - low terms of the reduction polynomial
//            bit_in           in  - current multiplier bit
//            t_out  [W-1:0] out - updated value
// Revision : 1.0 - initial release
// ============================================================================
module gf2m_mulx_step #(
  parameter int W = 163
) (
  input  logic [W-1:0] t_in,
  input  logic [W-1:0] a,
  input  logic [W-1:0] g,
  input  logic         bit_in,
  output logic [W-1:0] t_out
);

  logic [W-1:0] shifted;

  // Bit m shifted out of the top is replaced by g, since x^m == g(x) mod f.
  assign shifted = {t_in[W-2:0], 1'b0} ^ ({W{t_in[W-1]}} & g);
  assign t_out   = shifted ^ ({W{bit_in}} & a);

endmodule
`default_nettype wire

// File: rtl/gf2m_digit_mul.sv
`default_nettype none
// ============================================================================
// Module   : gf2m_digit_mul
// Purpose  : Digit-serial GF(2^m) multiplier. Computes a*B mod f, f = x^m+g,
//            consuming one DIGITAL-bit digit of B (MSB digit first) per cycle
//            with b_valid high. B spans NDIG = DATA_WIDTH/DIGITAL+1 digits.
// Ports    : clk      in  - clock, rising edge
//            rst      in  - asynchronous active-low reset
//            start    in  - operation request (IDLE only), latches a and g
//            a        in  - multiplicand [DATA_WIDTH-1:0]
//            g        in  - reduction polynomial low terms [DATA_WIDTH-1:0]
//            b        in  - multiplier digit [DIGITAL-1:0]
//            b_valid  in  - b holds a digit this cycle
//            abort    in  - (GF2M_ABORT_EN only) cancel the running operation
//            t_i_j    out - result, held until the next start
//            done     out - one-cycle pulse, t_i_j valid
// Config   : define GF2M_ABORT_EN to add the abort port.
// Revision : 1.0 - initial release
// ============================================================================
module gf2m_digit_mul
  import gf2m_pkg::*;
#(
  parameter int DIGITAL    = DIGITAL_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] g,
  input  logic [DIGITAL-1:0]    b,
  input  logic                  b_valid,
`ifdef GF2M_ABORT_EN
  input  logic                  abort,
`endif
  output logic [DATA_WIDTH-1:0] t_i_j,
  output logic                  done
);

  localparam int NDIG  = gf2m_ndig(DATA_WIDTH, DIGITAL);
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] g_q;
  logic [DATA_WIDTH-1:0] next_acc;
  logic                  last_digit;

  // Horner chain: stage 0 sees the accumulator and the digit MSB, so after
  // DIGITAL stages the result is acc*x^DIGITAL + a*digit, reduced mod f.
  logic [DATA_WIDTH-1:0] chain [DIGITAL+1];

  assign chain[0] = acc;

  generate
    for (genvar i = 0; i < DIGITAL; i++) begin : g_step
      gf2m_mulx_step #(
        .W(DATA_WIDTH)
      ) u_step (
        .t_in  (chain[i]),
        .a     (a_q),
        .g     (g_q),
        .bit_in(b[DIGITAL-1-i]),
        .t_out (chain[i+1])
      );
    end
  endgenerate

  assign next_acc   = chain[DIGITAL];
  assign last_digit = (cnt == CNT_W'(NDIG - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      a_q   <= '0;
      g_q   <= '0;
      t_i_j <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            g_q   <= g;
            acc   <= '0;
            cnt   <= '0;
            state <= CAL;
          end
        end
        CAL: begin
`ifdef GF2M_ABORT_EN
          // Abort wins over a digit arriving in the same cycle.
          if (abort) begin
            state <= IDLE;
          end else
`endif
          if (b_valid) begin
            acc <= next_acc;
            if (last_digit) begin
              t_i_j <= next_acc;
              state <= DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gf2m_digit_mul.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf2m_digit_mul
// Purpose  : Self-checking bench for gf2m_digit_mul. Directed vector table,
//            randomized operations against a polynomial-product reference
//            model, and hand-written reset / abort sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gf2m_digit_mul;

  localparam int DW   = 163;
  localparam int DG   = 16;
  localparam int NDIG = DW / DG + 1;
  localparam int BW   = NDIG * DG;
  localparam int PW   = DW + BW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] g = '0;
  logic [DG-1:0] b = '0;
  logic          b_valid = 1'b0;
`ifdef GF2M_ABORT_EN
  logic          abort = 1'b0;
`endif
  logic [DW-1:0] t_i_j;
  logic          done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gf2m_digit_mul #(
    .DIGITAL   (DG),
    .DATA_WIDTH(DW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .g      (g),
    .b      (b),
    .b_valid(b_valid),
`ifdef GF2M_ABORT_EN
    .abort  (abort),
`endif
    .t_i_j  (t_i_j),
    .done   (done)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] g;
    logic [BW-1:0] bb;
    int            stall_at;   // digit index before which b_valid drops
    int            stall_len;
    int            start_at;   // cycle of a spurious start pulse (0 = none)
    logic [DW-1:0] exp_t;
    int            exp_lat;
  } vec_t;

  vec_t tbl[6];

  // Full carry-less product, then long division by f = x^m + g.
  function automatic logic [DW-1:0] ref_mul(input logic [DW-1:0] aa,
                                            input logic [DW-1:0] gg,
                                            input logic [BW-1:0] bb);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < BW; i++)
      if (bb[i]) p = p ^ (PW'(aa) << i);
    for (int i = PW - 1; i >= DW; i--)
      if (p[i]) begin
        p[i] = 1'b0;
        p    = p ^ (PW'(gg) << (i - DW));
      end
    return p[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rand_dw();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Entered and left at a falling edge. Runs one operation, returns the
  // result captured with done and the done latency from the start edge.
  task automatic run_op(input vec_t v, output logic [DW-1:0] res,
                        output int lat);
    int d;
    int st;
    d   = 0;
    st  = 0;
    lat = -1;
    res = '0;
    start   = 1'b1;
    a       = v.a;
    g       = v.g;
    b_valid = 1'b1;              // ignored in IDLE
    b       = DG'($urandom);
    @(posedge clk);
    @(negedge clk);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      start = (cyc == v.start_at);
      a     = rand_dw();         // latched copies must be used
      g     = rand_dw();
      if (d == v.stall_at && st < v.stall_len) begin
        b_valid = 1'b0;
        b       = DG'($urandom);
        st++;
      end else if (d < NDIG) begin
        b_valid = 1'b1;
        b       = v.bb[(NDIG-1-d)*DG +: DG];
        d++;
      end else begin
        b_valid = 1'b1;          // ignored in DONE
        b       = DG'($urandom);
      end
      @(posedge clk);
      #1;
      if (done) begin
        lat = cyc;
        res = t_i_j;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    start   = 1'b0;
    b_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("done_single_pulse", DW'(done), DW'(0));
    chk("t_i_j_hold", t_i_j, res);
    @(negedge clk);
  endtask

  task automatic run_and_check(input string name, input vec_t v);
    logic [DW-1:0] res;
    int            lat;
    run_op(v, res, lat);
    chk({name, "_result"}, res, v.exp_t);
    chk({name, "_latency"}, DW'(lat), DW'(v.exp_lat));
  endtask

  initial begin
    logic [DW-1:0] res;
    logic [DW-1:0] prev;
    vec_t          v;
    logic [DW-1:0] top;
    top = '0;
    top[DW-1] = 1'b1;

    // a=1, B=1 -> 1
    tbl[0] = '{a: DW'(1), g: DW'('hC9), bb: BW'(1), stall_at: 0, stall_len: 0,
               start_at: 0, exp_t: DW'(1), exp_lat: 12};
    // a=x^162, B=x -> x^163 mod f = g
    tbl[1] = '{a: top, g: DW'('hC9), bb: BW'(2), stall_at: 0, stall_len: 0,
               start_at: 0, exp_t: DW'('hC9), exp_lat: 12};
    // three-cycle stall mid-stream delays done by exactly 3
    tbl[2] = '{a: DW'(1), g: DW'('hC9), bb: BW'(1), stall_at: 5, stall_len: 3,
               start_at: 0, exp_t: DW'(1), exp_lat: 15};
    // spurious start during CAL, a=x^5, B=x^7 -> x^12
    tbl[3] = '{a: DW'(1) << 5, g: DW'('hC9), bb: BW'(1) << 7, stall_at: 0,
               stall_len: 0, start_at: 4, exp_t: DW'('h1000), exp_lat: 12};
    // x^162*x^162 = x^324 = x^161 + x^168 + x^167 + x^164 with g=0xC9
    tbl[4] = '{a: top, g: DW'('hC9), bb: BW'(top), stall_at: 0, stall_len: 0,
               start_at: 12, exp_t: (DW'(1) << 161) | DW'('h1422), exp_lat: 12};
    // a=0 gives 0 whatever B is
    tbl[5] = '{a: '0, g: DW'('hC9), bb: BW'({DW{1'b1}}), stall_at: 2,
               stall_len: 1, start_at: 0, exp_t: '0, exp_lat: 13};

    // Reset state
    #12;
    chk("reset_t_i_j", t_i_j, '0);
    chk("reset_done", DW'(done), DW'(0));
    @(negedge clk);
    rst = 1'b1;                  // start offered on the very next edge

    for (int i = 0; i < 6; i++)
      run_and_check($sformatf("vec%0d", i), tbl[i]);

    // Randomized operations against the reference model
    for (int i = 0; i < 8; i++) begin
      v.a         = rand_dw();
      v.g         = rand_dw();
      v.bb        = BW'(rand_dw());
      v.stall_at  = $urandom_range(0, NDIG - 1);
      v.stall_len = $urandom_range(0, 4);
      v.start_at  = $urandom_range(0, 14);
      v.exp_t     = ref_mul(v.a, v.g, v.bb);
      v.exp_lat   = NDIG + 1 + v.stall_len;
      run_and_check($sformatf("rand%0d", i), v);
    end

    // Reset after 5 digits: outputs clear at once, then a fresh run works
    run_and_check("pre_reset", tbl[4]);
    start = 1'b1;
    a     = top;
    g     = DW'('hC9);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b_valid = 1'b1;
      b       = '0;
      @(posedge clk);
      @(negedge clk);
    end
    b = DG'(1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrun_reset_t_i_j", t_i_j, '0);
    chk("midrun_reset_done", DW'(done), DW'(0));
    @(negedge clk);
    b_valid = 1'b0;
    rst     = 1'b1;
    run_and_check("post_reset", tbl[1]);

`ifdef GF2M_ABORT_EN
    // Abort after 4 digits: back to IDLE, no done, result untouched
    prev  = t_i_j;
    start = 1'b1;
    a     = DW'(1);
    g     = DW'('hC9);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_valid = 1'b1;
      b       = DG'(i + 1);
      @(posedge clk);
      @(negedge clk);
    end
    abort   = 1'b1;
    b_valid = 1'b1;
    b       = DG'(5);
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    res   = '0;
    for (int i = 0; i < 20; i++) begin
      b_valid = 1'b1;
      b       = DG'(1);
      @(posedge clk);
      #1;
      if (done) res = DW'(1);
      @(negedge clk);
    end
    b_valid = 1'b0;
    chk("abort_no_done", res, '0);
    chk("abort_t_i_j_held", t_i_j, prev);
    run_and_check("post_abort", tbl[0]);
`else
    prev = '0;
    res  = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gf2m_digit_mul.md
GF2M_DIGIT_MUL -- requirements
Module: gf2m_digit_mul

Interface
REQ-001 The block SHALL have parameter DIGITAL, default 16, meaning the digit width in bits consumed per accepted beat.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 163, meaning the field degree m.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: operation request, sampled in IDLE only.
REQ-006 The block SHALL have port a, input, DATA_WIDTH bits: multiplicand, sampled with start.
REQ-007 The block SHALL have port g, input, DATA_WIDTH bits: reduction polynomial, the low terms of f(x)=x^m+g(x), sampled with start.
REQ-008 The block SHALL have port b, input, DIGITAL bits: the current multiplier digit, MSB digit first.
REQ-009 The block SHALL have port b_valid, input, 1 bit: b holds a valid digit this cycle.
REQ-010 The block SHALL have port t_i_j, output, DATA_WIDTH bits: result a*B mod f, held until the next start.
REQ-011 The block SHALL have port done, output, 1 bit: single-cycle pulse marking t_i_j as valid.

Function
REQ-012 The block SHALL derive the local constant NDIG = DATA_WIDTH/DIGITAL + 1 (11 at defaults); B is NDIG digits, zero-padded above bit m-1.
REQ-013 The block SHALL implement a state machine with states IDLE, CAL and DONE, encoded on 2 bits.
REQ-014 In IDLE with start=1, the block SHALL latch a and g, clear the accumulator and digit counter, and enter CAL.
REQ-015 In CAL, a digit SHALL be consumed only on a cycle with b_valid=1; with b_valid=0 the accumulator and counter SHALL hold (stall).
REQ-016 Each consumed digit SHALL update acc <= (acc*x^DIGITAL mod f) XOR (a*b mod f), computed as DIGITAL Horner steps MSB-first within one cycle, each step being t=t*x mod f followed by t^=a if the digit bit is set.
REQ-017 The counter SHALL run 0..NDIG-1; on the NDIG-th consumed digit, the block SHALL load the final value into t_i_j and enter DONE.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-019 With b_valid held high, done SHALL rise NDIG+1 cycles after the start-sampling edge (12 at defaults).
REQ-020 start asserted in CAL or DONE SHALL be ignored without affecting the running operation.
REQ-021 b_valid asserted in IDLE or DONE SHALL be ignored.
REQ-022 The mod-f reduction in every step SHALL XOR g into bits [m-1:0] when the shifted-out bit m is 1; all arithmetic SHALL be carry-less (XOR).

Reset
REQ-023 On rst=0, the block SHALL asynchronously force state=IDLE and clear the counter, accumulator, latched a/g, t_i_j and done to 0, including in the middle of an operation.
REQ-024 After rst is released, the block SHALL accept the first start on the first rising clk edge.

Configuration
REQ-025 When macro GF2M_ABORT_EN is defined, the block SHALL add input port abort (1 bit); abort=1 in CAL SHALL return the block to IDLE on the next edge with t_i_j unchanged and no done pulse, and abort SHALL take priority over a digit consumed in the same cycle.
REQ-026 When GF2M_ABORT_EN is undefined, the abort port and its logic SHALL be absent.

Structure
REQ-027 The state encodings and the default values of DIGITAL and DATA_WIDTH SHALL reside in the shared package gf2m_pkg.
REQ-028 The single-step datapath SHALL be the sub-module gf2m_mulx_step (t*x mod f with conditional XOR of a), instantiated DIGITAL times in a chain.

Verification
REQ-029 The bench SHALL apply g=0xC9, a=1, and digits 0x0000 x10 followed by 0x0001, all with b_valid high; the required response is done after 12 cycles with t_i_j=1.
REQ-030 The bench SHALL apply g=0xC9, a=bit162 set, and digits 0 x10 followed by 0x0002; the required response is t_i_j=0xC9 (x^163 mod f).
REQ-031 The bench SHALL repeat REQ-029 with b_valid low for 3 cycles mid-stream; the required response is an identical result with done delayed by exactly 3 cycles.
REQ-032 The bench SHALL pulse start again during CAL; the required response is an unchanged result and a single done pulse.
REQ-033 The bench SHALL assert rst=0 after 5 digits; the required response is all outputs at 0 immediately, after which a fresh run of REQ-030 SHALL pass.
REQ-034 With GF2M_ABORT_EN defined, the bench SHALL assert abort after 4 digits; the required response is a return to IDLE, no done pulse, and t_i_j holding its previous value.
